div_edge_ticker: RTL and testbench
==================================

DIV_EDGE_TICKER -- requirements
Module: div_edge_ticker

Interface
REQ-001 SHALL have parameter CNT_W, default 8, giving the tick counter width.
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port div_in, input, 2 bits: divided-clock levels from the upstream divider, asynchronous to clk.
REQ-005 SHALL have port sel, input, 1 bit: selects which div_in bit's tick drives the counter.
REQ-006 SHALL have port enable, input, 1 bit: counter advance enable.
REQ-007 SHALL have port term, input, CNT_W bits: counter terminal value.
REQ-008 SHALL have port load, input, 1 bit: synchronous counter load strobe.
REQ-009 SHALL have port load_val, input, CNT_W bits: counter load value.
REQ-010 SHALL have port evt_ready, input, 1 bit: consumer accepts the wrap event.
REQ-011 SHALL have port clr_ovf, input, 1 bit: clears the overflow flag.
REQ-012 SHALL have port tick, output, 2 bits: one-cycle rising-edge pulse per div_in bit.
REQ-013 SHALL have port count, output, CNT_W bits: current counter value.
REQ-014 SHALL have port wrap, output, 1 bit: one-cycle pulse on counter wrap.
REQ-015 SHALL have port evt_valid, output, 1 bit: pending wrap event.
REQ-016 SHALL have port ovf, output, 1 bit: sticky event-overflow flag.

Function
REQ-017 SHALL synchronise each div_in bit through two flops (s1, s2), plus a history flop s3 holding the previous s2.
REQ-018 SHALL register tick[i] = s2[i] & ~s3[i]; tick is high for exactly one cycle, 3 clk edges after a div_in[i] rise that meets setup.
REQ-019 SHALL ignore falling edges of div_in; a div_in high pulse shorter than one clk period may be missed, and SHALL never produce two ticks.
REQ-020 SHALL define the selected tick as tick[sel], with sel sampled in the same cycle the tick is high.
REQ-021 Counter priority SHALL be: load (count <= load_val, no wrap) > (enable & selected tick) > hold.
REQ-022 On an advance, if count == term then count <= 0 and wrap SHALL pulse that same edge; otherwise count <= count+1.
REQ-023 If term == 0, every advance SHALL pulse wrap and keep count at 0.
REQ-024 If count > term (after a load), count SHALL increment modulo 2^CNT_W until it equals term; the 2^CNT_W-1 -> 0 rollover SHALL NOT pulse wrap.
REQ-025 wrap SHALL set evt_valid; evt_valid SHALL clear on an edge with evt_valid & evt_ready unless a new wrap occurs on that same edge, in which case it stays 1.
REQ-026 A wrap while evt_valid=1 and evt_ready=0 SHALL set ovf; ovf SHALL stay set until clr_ovf=1 or reset; if set and clear coincide, set wins.
REQ-027 A load during a pending event SHALL NOT alter evt_valid or ovf.

Reset
REQ-028 While rst_n=0, s1, s2, s3, tick, count, wrap, evt_valid and ovf SHALL be 0 immediately, regardless of clk.
REQ-029 After rst_n rises, a div_in bit already high SHALL produce one tick once its synchroniser fills (s3 starts at 0); benches SHALL expect it.
REQ-030 Reset mid-event SHALL drop the pending event without setting ovf.

Configuration
REQ-031 Macro DIV_TICKER_GLITCH_FILTER_EN, when defined, SHALL add flop s4 and set tick[i] = s2[i] & s3[i] & ~s4[i] (high for two samples after low), adding one cycle of latency (4 edges) and rejecting 1-cycle synchronised glitches.
REQ-032 Without DIV_TICKER_GLITCH_FILTER_EN, the tick SHALL follow REQ-018 exactly and s4 SHALL NOT exist.

Verification
REQ-033 Reset, then div_in[0] square wave of period 8 clk, sel=0, enable=1, term=3 -> tick[0] every 8 cycles; count 0,1,2,3,0; wrap on every 4th tick.
REQ-034 Wrap with evt_ready=0, then a second wrap -> evt_valid=1, ovf=1; clr_ovf pulse -> ovf=0 while evt_valid stays 1.
REQ-035 load=1, load_val=5 on the same cycle as the selected tick, term=3 -> count=5, no wrap; count rolls 255->0 silently, then wrap at the 0->3->0 transition.
REQ-036 evt_ready=1 on the same edge as a new wrap -> evt_valid stays 1, ovf stays 0.
REQ-037 1-cycle div_in[1] glitch -> tick[1] pulses without the macro; no tick[1] with DIV_TICKER_GLITCH_FILTER_EN.
REQ-038 rst_n low asynchronously mid-count (count=2, evt_valid=1) -> all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/div_edge_ticker.sv
// Synchronises two divided-clock levels, emits rising-edge ticks, and counts selected ticks
// with wrap event handshake. Define DIV_TICKER_GLITCH_FILTER_EN to add a 2-sample glitch filter.
module div_edge_ticker #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       div_in,
  input  logic             sel,
  input  logic             enable,
  input  logic [CNT_W-1:0] term,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             evt_ready,
  input  logic             clr_ovf,
  output logic [1:0]       tick,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             evt_valid,
  output logic             ovf
);

  logic [1:0]       s1_q, s2_q, s3_q;
  logic [1:0]       tick_q, tick_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             evt_valid_q, evt_valid_d;
  logic             ovf_q, ovf_d;
  logic             advance;

`ifdef DIV_TICKER_GLITCH_FILTER_EN
  logic [1:0] s4_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s4_q <= 2'b00;
    end else begin
      s4_q <= s3_q;
    end
  end

  // Level must be seen high on two consecutive samples after a low.
  always_comb begin
    tick_d = s2_q & s3_q & ~s4_q;
  end
`else
  always_comb begin
    tick_d = s2_q & ~s3_q;
  end
`endif

  always_comb begin
    advance     = enable & tick_q[sel];
    count_d     = count_q;
    wrap_d      = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (advance) begin
      // Only reaching term wraps; the natural 2^CNT_W rollover is silent.
      if (count_q == term) begin
        count_d = '0;
        wrap_d  = 1'b1;
      end else begin
        count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
    evt_valid_d = wrap_d | (evt_valid_q & ~evt_ready);
    ovf_d       = (wrap_d & evt_valid_q & ~evt_ready) | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= 2'b00;
      s2_q        <= 2'b00;
      s3_q        <= 2'b00;
      tick_q      <= 2'b00;
      count_q     <= '0;
      wrap_q      <= 1'b0;
      evt_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      s1_q        <= div_in;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      tick_q      <= tick_d;
      count_q     <= count_d;
      wrap_q      <= wrap_d;
      evt_valid_q <= evt_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign tick      = tick_q;
  assign count     = count_q;
  assign wrap      = wrap_q;
  assign evt_valid = evt_valid_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_div_edge_ticker.sv
// Randomised self-checking bench for div_edge_ticker against a cycle-level behavioural model
// built from a history of sampled div_in levels and the counter/event rules.
module tb_div_edge_ticker;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   div_in;
  logic         sel, enable, load, evt_ready, clr_ovf;
  logic [W-1:0] term, load_val;
  logic [1:0]   tick;
  logic [W-1:0] count;
  logic         wrap, evt_valid, ovf;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [1:0]   dh [4];   // dh[0] = div_in sampled at the most recent edge
  logic [1:0]   m_tick;
  logic [W-1:0] m_count;
  logic         m_wrap, m_evt, m_ovf;
  logic [12:0]  obs, exp_v;

  div_edge_ticker #(.CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .div_in(div_in), .sel(sel), .enable(enable), .term(term),
    .load(load), .load_val(load_val), .evt_ready(evt_ready), .clr_ovf(clr_ovf),
    .tick(tick), .count(count), .wrap(wrap), .evt_valid(evt_valid), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int i = 0; i < 4; i++) dh[i] = 2'b00;
    m_tick = 2'b00; m_count = '0; m_wrap = 1'b0; m_evt = 1'b0; m_ovf = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs present before the edge.
  task automatic model_step();
    logic [1:0]   nt;
    logic [1:0]   d;
    logic [W-1:0] nc;
    logic         wev, ne, no;
`ifdef DIV_TICKER_GLITCH_FILTER_EN
    nt = dh[1] & dh[2] & ~dh[3];
`else
    nt = dh[1] & ~dh[2];
`endif
    d   = div_in;
    nc  = m_count;
    wev = 1'b0;
    if (load) nc = load_val;
    else if (enable && m_tick[sel]) begin
      if (m_count == term) begin nc = '0; wev = 1'b1; end
      else nc = m_count + 8'd1;
    end
    ne = wev | (m_evt & ~evt_ready);
    no = (wev & m_evt & ~evt_ready) | (m_ovf & ~clr_ovf);
    @(posedge clk);
    dh[3] = dh[2]; dh[2] = dh[1]; dh[1] = dh[0]; dh[0] = d;
    m_tick = nt; m_count = nc; m_wrap = wev; m_evt = ne; m_ovf = no;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; div_in = 2'b00; sel = 1'b0; enable = 1'b0; load = 1'b0; evt_ready = 1'b0;
    clr_ovf = 1'b0; term = '0; load_val = '0;
    model_reset();
    #3;
    obs = {tick, count, wrap, evt_valid, ovf};
    n_tests++;
    if (obs !== 13'd0) begin
      n_fail++; $display("FAIL reset_state: got %h want %h", obs, 13'd0);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_square_wave();
    int n_wrap = 0, n_tick = 0;
    sel = 1'b0; enable = 1'b1; term = 8'd3; evt_ready = 1'b1;
    for (int c = 0; c < 64; c++) begin
      div_in = {1'b0, (c % 8) < 4};
      model_step();
      obs = {tick, count, wrap, evt_valid, ovf};
      exp_v = {m_tick, m_count, m_wrap, m_evt, m_ovf};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL square_wave c=%0d: got %h want %h", c, obs, exp_v);
      end
      n_wrap += int'(wrap);
      n_tick += int'(tick[0]);
    end
    n_tests++;
    if (n_tick != 8 || n_wrap != 2) begin
      n_fail++;
      $display("FAIL square_counts: got ticks=%0d wraps=%0d want ticks=8 wraps=2", n_tick, n_wrap);
    end
  endtask

  task automatic test_overflow();
    term = 8'd0; evt_ready = 1'b0; sel = 1'b0; enable = 1'b1;
    for (int c = 0; c < 24; c++) begin
      div_in = {1'b0, (c % 8) < 4};
      model_step();
      obs = {tick, count, wrap, evt_valid, ovf};
      exp_v = {m_tick, m_count, m_wrap, m_evt, m_ovf};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL overflow c=%0d: got %h want %h", c, obs, exp_v);
      end
    end
    n_tests++;
    if ({evt_valid, ovf} !== 2'b11) begin
      n_fail++; $display("FAIL ovf_set: got evt_valid,ovf=%b want 11", {evt_valid, ovf});
    end
    div_in = 2'b00; clr_ovf = 1'b1;
    model_step();
    clr_ovf = 1'b0;
    n_tests++;
    if ({evt_valid, ovf} !== 2'b10 || {m_evt, m_ovf} !== 2'b10) begin
      n_fail++; $display("FAIL ovf_clear: got evt_valid,ovf=%b want 10", {evt_valid, ovf});
    end
  endtask

  task automatic test_back_to_back();
    bit hit = 0;
    term = 8'd0; sel = 1'b0; enable = 1'b1;
    for (int c = 0; c < 16; c++) begin
      div_in = {1'b0, c < 4};
      evt_ready = m_tick[0];
      model_step();
      obs = {tick, count, wrap, evt_valid, ovf};
      exp_v = {m_tick, m_count, m_wrap, m_evt, m_ovf};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL back_to_back c=%0d: got %h want %h", c, obs, exp_v);
      end
      if (wrap) begin
        hit = 1;
        n_tests++;
        if ({evt_valid, ovf} !== 2'b10) begin
          n_fail++; $display("FAIL ready_same_edge: got evt_valid,ovf=%b want 10", {evt_valid, ovf});
        end
      end
    end
    n_tests++;
    if (!hit) begin
      n_fail++; $display("FAIL ready_same_edge_seen: got no wrap, want one wrap");
    end
    evt_ready = 1'b1;
    model_step();
  endtask

  task automatic test_load();
    bit loaded = 0, rolled = 0, done = 0;
    int early_wraps = 0;
    term = 8'd3; sel = 1'b0; enable = 1'b1; evt_ready = 1'b1;
    for (int c = 0; c < 1400 && !done; c++) begin
      div_in = {1'b0, (c % 4) < 2};
      if (!loaded && m_tick[0]) begin load = 1'b1; load_val = 8'd5; end
      model_step();
      obs = {tick, count, wrap, evt_valid, ovf};
      exp_v = {m_tick, m_count, m_wrap, m_evt, m_ovf};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL load c=%0d: got %h want %h", c, obs, exp_v);
      end
      if (load) begin
        load = 1'b0; loaded = 1;
        n_tests++;
        if (count !== 8'd5 || wrap !== 1'b0) begin
          n_fail++; $display("FAIL load_prio: got count=%0d wrap=%b want 5 0", count, wrap);
        end
      end else if (loaded && !rolled) begin
        early_wraps += int'(wrap);
        if (count == 8'd0) rolled = 1;
      end else if (rolled && wrap) begin
        done = 1;
        n_tests++;
        if (count !== 8'd0) begin
          n_fail++; $display("FAIL wrap_after_roll: got count=%0d want 0", count);
        end
      end
    end
    n_tests++;
    if (!done || early_wraps != 0) begin
      n_fail++;
      $display("FAIL silent_rollover: got done=%0d early_wraps=%0d want 1 0", done, early_wraps);
    end
  endtask

  task automatic test_glitch();
    int n1 = 0;
    int want;
`ifdef DIV_TICKER_GLITCH_FILTER_EN
    want = 0;
`else
    want = 1;
`endif
    sel = 1'b1; enable = 1'b0;
    for (int c = 0; c < 14; c++) begin
      div_in = {c == 4, 1'b0};
      model_step();
      obs = {tick, count, wrap, evt_valid, ovf};
      exp_v = {m_tick, m_count, m_wrap, m_evt, m_ovf};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL glitch c=%0d: got %h want %h", c, obs, exp_v);
      end
      n1 += int'(tick[1]);
    end
    n_tests++;
    if (n1 != want) begin
      n_fail++; $display("FAIL glitch_ticks: got %0d want %0d", n1, want);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) div_in[0] = ~div_in[0];
      if ($urandom_range(0, 2) == 0) div_in[1] = ~div_in[1];
      sel       = 1'($urandom_range(0, 1));
      enable    = ($urandom_range(0, 7) != 0);
      term      = W'($urandom_range(0, 5));
      load      = ($urandom_range(0, 31) == 0);
      load_val  = W'($urandom);
      evt_ready = ($urandom_range(0, 2) == 0);
      clr_ovf   = ($urandom_range(0, 15) == 0);
      model_step();
      obs = {tick, count, wrap, evt_valid, ovf};
      exp_v = {m_tick, m_count, m_wrap, m_evt, m_ovf};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL random c=%0d: got %h want %h", c, obs, exp_v);
      end
    end
    load = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic test_async_reset();
    bit reached = 0;
    int t0 = 0, t1 = 0;
    term = 8'd3; sel = 1'b0; enable = 1'b1; evt_ready = 1'b0; clr_ovf = 1'b0;
    load = 1'b1; load_val = 8'd3;
    for (int c = 0; c < 100 && !reached; c++) begin
      div_in = {1'b0, (c % 4) < 2};
      model_step();
      load = 1'b0;
      if (m_count == 8'd2 && m_evt) reached = 1;
    end
    n_tests++;
    if (!reached || count !== 8'd2 || evt_valid !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset: got count=%0d evt_valid=%b want 2 1", count, evt_valid);
    end
    #2;
    rst_n = 1'b0;
    div_in = 2'b11;
    #1;
    model_reset();
    obs = {tick, count, wrap, evt_valid, ovf};
    n_tests++;
    if (obs !== 13'd0) begin
      n_fail++; $display("FAIL async_reset: got %h want %h", obs, 13'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      model_step();
      obs = {tick, count, wrap, evt_valid, ovf};
      exp_v = {m_tick, m_count, m_wrap, m_evt, m_ovf};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL post_reset c=%0d: got %h want %h", c, obs, exp_v);
      end
      t0 += int'(tick[0]);
      t1 += int'(tick[1]);
    end
    n_tests++;
    if (t0 != 1 || t1 != 1 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL high_at_reset: got ticks=%0d,%0d ovf=%b want 1,1 0", t0, t1, ovf);
    end
  endtask

  initial begin
    test_reset();
    test_square_wave();
    test_overflow();
    test_back_to_back();
    test_load();
    test_glitch();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
